// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Runs the request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first,
// odd parity and stop. It then checks the device ACK and drives both open-drain lines
// through pull-low enables.
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned TIMEOUT_CYC = 750_000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   output logic       tx_done_o,
   output logic       tx_err_o
);

   localparam int unsigned MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_RTS       = 3'd2;
   localparam logic [2:0] S_XFER      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;
   localparam logic [2:0] S_ERR       = 3'd6;

   // Zero-length counts would make the cycle counters wrap.
   if (CLK_FREQ_HZ == 0 || INHIBIT_CYC == 0 || TIMEOUT_CYC == 0) begin : g_param_check
      $error("ps2_host_tx: CLK_FREQ_HZ, INHIBIT_CYC and TIMEOUT_CYC must be non-zero");
   end

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_prev_q;
   logic          clk_s, dat_s, clk_fall;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [8:0]    frame_q, frame_d;
   logic          clk_oe_q, dat_oe_q, dat_oe_d;
   logic          ready_q, done_q, err_q;
   logic          timeout;

   assign clk_s    = clk_sync_q[1];
   assign dat_s    = dat_sync_q[1];
   assign clk_fall = clk_prev_q & ~clk_s;
   assign timeout  = (timer_q == TO_LAST);

   // Two-flop synchronizers on the pads, plus one delay stage for falling-edge detect.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
         clk_prev_q <= clk_s;
      end
   end

   // Next-state logic: sequencing, cycle timers, edge count and frame shifting.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      dat_oe_d = dat_oe_q;
      case (state_q)
         S_IDLE: begin
            if (tx_valid_i) begin
               state_d = S_INHIBIT;
               frame_d = {~^tx_data_i, tx_data_i};
               cnt_d   = 4'd0;
               timer_d = '0;
            end
         end
         S_INHIBIT: begin
            if (timer_q == INH_LAST) begin
               state_d = S_RTS;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RTS: begin
            state_d = S_XFER;
            timer_d = '0;
         end
         S_XFER: begin
            if (timeout) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TW'(1);
               if (clk_fall) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd10) begin
                     // 11th edge: device must be holding data low as ACK.
                     state_d = dat_s ? S_ERR : S_WAIT_IDLE;
                  end else begin
                     // Bits 0..7, then parity, then the 1 shifted in acts as the stop bit.
                     dat_oe_d = ~frame_q[0];
                     frame_d  = {1'b1, frame_q[8:1]};
                  end
               end
            end
         end
         S_WAIT_IDLE: begin
            if (timeout) begin
               state_d = S_ERR;
            end else if (clk_s && dat_s) begin
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Start bit is held from RTS until the first edge; outside XFER the data line is free.
      if (state_d == S_RTS) begin
         dat_oe_d = 1'b1;
      end else if (state_d != S_XFER) begin
         dat_oe_d = 1'b0;
      end
   end

   // State and registered outputs, decoded from next state so the pads never glitch.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         cnt_q    <= 4'd0;
         frame_q  <= '1;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         clk_oe_q <= (state_d == S_INHIBIT) || (state_d == S_RTS);
         dat_oe_q <= dat_oe_d;
         ready_q  <= (state_d == S_IDLE);
         done_q   <= (state_d == S_DONE);
         err_q    <= (state_d == S_ERR);
      end
   end

   assign ps2_clk_oe_o = clk_oe_q;
   assign ps2_dat_oe_o = dat_oe_q;
   assign tx_ready_o   = ready_q;
   assign busy_o       = ~ready_q;
   assign tx_done_o    = done_q;
   assign tx_err_o     = err_q;

endmodule
